// File: rtl/except_ctrl_pkg.sv
// Shared constants for the MEM-stage exception front end: exception codes,
// flag bit positions, CP0 register addresses and the drain FSM state type.
package except_ctrl_pkg;

  localparam int          RegBus    = 32;
  localparam logic        RstEnable = 1'b1;

  localparam logic [31:0] EXC_INT          = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_OV           = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  localparam int FLAG_SYSCALL      = 8;
  localparam int FLAG_INST_INVALID = 9;
  localparam int FLAG_TRAP         = 10;
  localparam int FLAG_OV           = 11;
  localparam int FLAG_ERET         = 12;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Cause bits a WB-stage mtc0 is allowed to overwrite (IP[1:0], WP/IV)
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00c0_0300;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

  function automatic logic int_pending(input logic [RegBus-1:0] status,
                                       input logic [RegBus-1:0] cause);
    return ((cause[15:8] & status[15:8]) != 8'h00) && !status[1] && status[0];
  endfunction

endpackage

// File: rtl/except_ctrl_if.sv
// MEM-stage exception bundle: flags and CP0 state in, flush/redirect and the
// cp0_reg exception stream out. The pipeline is master, except_ctrl is slave.
interface except_ctrl_if;
  import except_ctrl_pkg::*;

  logic [RegBus-1:0] mem_excepttype_i;
  logic [RegBus-1:0] mem_inst_addr_i;
  logic              mem_is_in_delayslot_i;
  logic [RegBus-1:0] cp0_status_i;
  logic [RegBus-1:0] cp0_cause_i;
  logic [RegBus-1:0] cp0_epc_i;
  logic              wb_cp0_we_i;
  logic [4:0]        wb_cp0_waddr_i;
  logic [RegBus-1:0] wb_cp0_data_i;

  logic [RegBus-1:0] excepttype_o;
  logic [RegBus-1:0] current_inst_addr_o;
  logic              is_in_delayslot_o;
  logic              flush_o;
  logic [RegBus-1:0] new_pc_o;
  logic              busy_o;

  modport master (
    output mem_excepttype_i, mem_inst_addr_i, mem_is_in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    input  flush_o, new_pc_o, busy_o
  );

  modport slave (
    input  mem_excepttype_i, mem_inst_addr_i, mem_is_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    output flush_o, new_pc_o, busy_o
  );

endinterface

// File: rtl/except_ctrl_cp0_bypass.sv
// Forwards an in-flight WB-stage mtc0 onto the CP0 Status/Cause/EPC values so
// exception detection sees the architecturally newest state.
module cp0_bypass
  import except_ctrl_pkg::*;
(
  input  logic [RegBus-1:0] i_cp0_status,
  input  logic [RegBus-1:0] i_cp0_cause,
  input  logic [RegBus-1:0] i_cp0_epc,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_waddr,
  input  logic [RegBus-1:0] i_wb_data,
  output logic [RegBus-1:0] o_status,
  output logic [RegBus-1:0] o_cause,
  output logic [RegBus-1:0] o_epc
);

  logic w_hit_status;
  logic w_hit_cause;
  logic w_hit_epc;

  assign w_hit_status = i_wb_we && (i_wb_waddr == CP0_REG_STATUS);
  assign w_hit_cause  = i_wb_we && (i_wb_waddr == CP0_REG_CAUSE);
  assign w_hit_epc    = i_wb_we && (i_wb_waddr == CP0_REG_EPC);

  assign o_status = w_hit_status ? i_wb_data : i_cp0_status;
  assign o_epc    = w_hit_epc    ? i_wb_data : i_cp0_epc;
  // Only the software-writable Cause fields are forwarded; the rest is hardware-owned
  assign o_cause  = w_hit_cause
                  ? ((i_cp0_cause & ~CAUSE_WR_MASK) | (i_wb_data & CAUSE_WR_MASK))
                  : i_cp0_cause;

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception priority encoder with flush/redirect generation and a
// drain FSM that ignores squashed instructions for a few cycles after a flush.
//   state    | meaning
//   ST_IDLE  | detection enabled
//   ST_DRAIN | post-flush blanking, r_cnt counts down to 0
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [RegBus-1:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int                DRAIN_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  except_ctrl_if.slave bus
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  drain_state_t      r_state;
  drain_state_t      w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;

  logic [RegBus-1:0] w_status;
  logic [RegBus-1:0] w_cause;
  logic [RegBus-1:0] w_epc;
  logic [RegBus-1:0] w_flags;
  logic [RegBus-1:0] w_excepttype;
  logic [RegBus-1:0] w_new_pc;
  logic              w_flush;
  logic              w_detect;
  logic              w_in_rst;
  logic              w_unused_flags;

  cp0_bypass u_cp0_bypass (
    .i_cp0_status (bus.cp0_status_i),
    .i_cp0_cause  (bus.cp0_cause_i),
    .i_cp0_epc    (bus.cp0_epc_i),
    .i_wb_we      (bus.wb_cp0_we_i),
    .i_wb_waddr   (bus.wb_cp0_waddr_i),
    .i_wb_data    (bus.wb_cp0_data_i),
    .o_status     (w_status),
    .o_cause      (w_cause),
    .o_epc        (w_epc)
  );

  assign w_in_rst       = (rst == RstEnable);
  assign w_flags        = bus.mem_excepttype_i;
  assign w_unused_flags = ^{w_flags[31:13], w_flags[7:0]};
  assign w_detect       = !w_in_rst && (r_state == ST_IDLE) && (bus.mem_inst_addr_i != '0);

  // Interrupt outranks synchronous flags so EPC lands on this PC and it re-executes
  always_comb begin
    w_excepttype = '0;
    if (w_detect) begin
      if (int_pending(w_status, w_cause))  w_excepttype = EXC_INT;
      else if (w_flags[FLAG_SYSCALL])      w_excepttype = EXC_SYSCALL;
      else if (w_flags[FLAG_INST_INVALID]) w_excepttype = EXC_INST_INVALID;
      else if (w_flags[FLAG_TRAP])         w_excepttype = EXC_TRAP;
      else if (w_flags[FLAG_OV])           w_excepttype = EXC_OV;
      else if (w_flags[FLAG_ERET])         w_excepttype = EXC_ERET;
    end
  end

  assign w_flush = (w_excepttype != '0);

  always_comb begin
    w_new_pc = '0;
    if (w_excepttype == EXC_ERET) w_new_pc = w_epc;
    else if (w_flush)             w_new_pc = EXC_VECTOR;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_flush) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.excepttype_o        = w_excepttype;
  assign bus.flush_o             = w_flush;
  assign bus.new_pc_o            = w_new_pc;
  assign bus.current_inst_addr_o = w_in_rst ? '0 : bus.mem_inst_addr_i;
  assign bus.is_in_delayslot_o   = !w_in_rst && bus.mem_is_in_delayslot_i;
  assign bus.busy_o              = !w_in_rst && (r_state == ST_DRAIN);

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- MEM-stage exception front end. Produces the exception stream that cp0_reg consumes: excepttype, current instruction address, delay-slot flag.
- Inputs are the MEM-stage exception flags and CP0 Status/Cause/EPC. In-flight WB-stage mtc0 writes are bypassed onto those CP0 values.
- Outputs are a pipeline flush and the redirect PC (exception vector or EPC).
- A drain FSM blocks repeat triggers from squashed instructions after each flush.

Parameters:
- EXC_VECTOR, 32'h00000020: redirect PC for all exceptions except eret.
- DRAIN_CYCLES, 2: cycles after a flush during which detection is blocked (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (`RstEnable)
- mem_excepttype_i  in  32  MEM flags: [8] syscall, [9] invalid inst, [10] trap, [11] overflow, [12] eret
- mem_inst_addr_i  in  32  MEM instruction PC; 0 means bubble
- mem_is_in_delayslot_i  in  1  MEM instruction is in a delay slot
- cp0_status_i  in  32  Status register from cp0_reg
- cp0_cause_i  in  32  Cause register from cp0_reg
- cp0_epc_i  in  32  EPC register from cp0_reg
- wb_cp0_we_i  in  1  WB-stage CP0 write enable
- wb_cp0_waddr_i  in  5  WB-stage CP0 write address
- wb_cp0_data_i  in  32  WB-stage CP0 write data
- excepttype_o  out  32  exception code to cp0_reg
- current_inst_addr_o  out  32  faulting PC to cp0_reg
- is_in_delayslot_o  out  1  delay-slot flag to cp0_reg
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect target, valid while flush_o=1
- busy_o  out  1  drain FSM is not IDLE

Behaviour:
- Bypass (combinational):
  - WB write to Status or EPC with matching address replaces the whole value.
  - WB write to Cause replaces only bits [9:8] and [23:22]. All other Cause bits come from cp0_cause_i.
- Interrupt condition:
  - (cause[15:8] & status[15:8]) != 0, and status[1] (EXL) == 0, and status[0] (IE) == 1.
  - Uses the bypassed values.
- Detection runs only when state == IDLE and mem_inst_addr_i != 0. Otherwise excepttype_o = 0.
- Priority, first match wins:
  - interrupt: 32'h1
  - syscall: 32'h8
  - invalid inst: 32'ha
  - trap: 32'hd
  - overflow: 32'hc
  - eret: 32'he
  - none: 0
- Same-cycle outputs (combinational, no latency), so cp0_reg updates EPC/Cause on the same edge:
  - excepttype_o
  - current_inst_addr_o = mem_inst_addr_i
  - is_in_delayslot_o = mem_is_in_delayslot_i
  - flush_o = (excepttype_o != 0)
- new_pc_o:
  - EXC_VECTOR for codes 1, 8, a, c, d.
  - Bypassed EPC for code e.
  - 0 when no flush.
- FSM states are IDLE and DRAIN.
  - IDLE -> DRAIN on flush_o; drain counter loads DRAIN_CYCLES-1.
  - In DRAIN, the counter decrements each cycle; at 0 go to IDLE.
  - While in DRAIN, excepttype_o, flush_o and new_pc_o are 0, and busy_o = 1.
- Simultaneous events:
  - Interrupt plus a synchronous flag: interrupt wins. EPC = this PC; the instruction is re-executed after eret.
  - eret with EXL already 0 is still reported as 32'he.
- Reset (any cycle, including mid-DRAIN): state goes to IDLE and the counter to 0. All outputs are 0 while rst is high; busy_o = 0.
- Width rules: the counter is 4 bits; address and data fields are 32-bit unsigned.

Decomposition:
- Shared package/defines.v:
  - exception code constants EXC_INT, EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV, EXC_ERET.
  - flag bit indices for mem_excepttype_i.
  - CP0 addresses (CP0_REG_STATUS, CP0_REG_CAUSE, CP0_REG_EPC).
  - RegBus, RstEnable.
- One sub-module: cp0_bypass, purely combinational, producing the bypassed Status/Cause/EPC. Priority encoding and the FSM stay in except_ctrl.

Test Plan:
- Interrupt taken: status=32'h10000401, cause[15:8]=8'h04, pc=32'h100 -> excepttype_o=1, flush_o=1, new_pc_o=32'h20. Detection then blocked for 2 cycles; busy_o=1 for exactly 2 cycles.
- Syscall in a delay slot: flag bit 8, delayslot=1, pc=32'h204 -> excepttype_o=8, is_in_delayslot_o=1, current_inst_addr_o=32'h204, new_pc_o=32'h20.
- eret with a WB bypass: wb writes EPC=32'h300 in the same cycle as eret, cp0_epc_i=32'h111 -> excepttype_o=32'he, new_pc_o=32'h300.
- Masking via bypass: cp0_status IE=1, but WB writes Status with IE=0; pending interrupt plus overflow -> excepttype_o=32'hc.
- Drain suppression: overflow at cycle N, then invalid-inst flags at N+1 and N+2 -> flush only at N. Invalid-inst is accepted at N+3 if still presented.
- Bubble and reset: pc=0 with syscall set -> no flush. rst asserted mid-DRAIN -> busy_o=0 the next cycle, and detection resumes after rst deasserts.
